// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolution with a PC-indexed 2-bit BHT for fetch prediction
// and a multi-cycle flush FSM on misprediction. Define BRU_PERF_CNT_EN for perf counters.
module branch_resolve_bht #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned BHT_ENTRIES  = 16,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  i_fetch_pc,
  output logic             o_pred_taken,
  input  logic             i_ex_valid,
  input  logic [PC_W-1:0]  i_ex_pc,
  input  logic             i_pred_taken,
  input  logic [XLEN-1:0]  o_rs1,
  input  logic [XLEN-1:0]  o_rs2,
  input  logic [4:0]       BrOp,
  output logic             NextPCSrc,
  output logic             o_mispredict,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mp_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]      state;
  logic [FC_W-1:0] flush_cnt;
  logic [1:0]      bht [BHT_ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic            is_cond_op;
  logic            br_taken;
  logic            cond;

  // Only the word-index bits address the table; the rest are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_fetch_pc[PC_W-1:IDX_W+2], i_fetch_pc[1:0],
                            i_ex_pc[PC_W-1:IDX_W+2], i_ex_pc[1:0]};

  assign fetch_idx    = i_fetch_pc[IDX_W+1:2];
  assign ex_idx       = i_ex_pc[IDX_W+1:2];
  assign o_pred_taken = bht[fetch_idx][1];

  always_comb begin
    br_taken = 1'b0;
    case (BrOp[2:0])
      3'b000:  br_taken = (o_rs1 == o_rs2);
      3'b001:  br_taken = (o_rs1 != o_rs2);
      3'b100:  br_taken = ($signed(o_rs1) <  $signed(o_rs2));
      3'b101:  br_taken = ($signed(o_rs1) >= $signed(o_rs2));
      3'b110:  br_taken = (o_rs1 <  o_rs2);
      3'b111:  br_taken = (o_rs1 >= o_rs2);
      default: br_taken = 1'b0;
    endcase
  end

  assign is_cond_op   = (BrOp[4:3] == 2'b01);
  assign NextPCSrc    = BrOp[4] | (is_cond_op & br_taken);
  assign cond         = i_ex_valid & is_cond_op & (state == S_IDLE);
  assign o_mispredict = cond & (NextPCSrc != i_pred_taken);
  assign o_flush      = (state == S_FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (cond) begin
      if (NextPCSrc) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

  // Counter is loaded with FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (o_mispredict) begin
            state     <= S_FLUSH;
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
          end
        end
        S_FLUSH: begin
          if (flush_cnt == '0) state <= S_IDLE;
          else                 flush_cnt <= flush_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (cond && (br_cnt != '1))         br_cnt <= br_cnt + 1'b1;
      if (o_mispredict && (mp_cnt != '1)) mp_cnt <= mp_cnt + 1'b1;
    end
  end

  assign o_br_cnt = br_cnt;
  assign o_mp_cnt = mp_cnt;
`else
  assign o_br_cnt = '0;
  assign o_mp_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Self-checking bench for branch_resolve_bht: directed scenarios plus randomized
// traffic compared against a behavioural table/flush model.
module tb_branch_resolve_bht;
  localparam int XLEN = 32, PC_W = 32, BHT_ENTRIES = 16, FLUSH_CYCLES = 2, CNT_W = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PC_W-1:0] fetch_pc;
  logic            pred_taken;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic            ex_pred;
  logic [XLEN-1:0] rs1, rs2;
  logic [4:0]      br_op;
  logic            next_pc_src, mispredict, flush;
  logic [CNT_W-1:0] br_cnt, mp_cnt;

  always #5 clk = ~clk;

  branch_resolve_bht #(
    .XLEN(XLEN), .PC_W(PC_W), .BHT_ENTRIES(BHT_ENTRIES),
    .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_fetch_pc(fetch_pc), .o_pred_taken(pred_taken),
    .i_ex_valid(ex_valid), .i_ex_pc(ex_pc), .i_pred_taken(ex_pred),
    .o_rs1(rs1), .o_rs2(rs2), .BrOp(br_op),
    .NextPCSrc(next_pc_src), .o_mispredict(mispredict), .o_flush(flush),
    .o_br_cnt(br_cnt), .o_mp_cnt(mp_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: counter value per table slot, remaining flush cycles, event totals.
  int          ref_bht [BHT_ENTRIES];
  int          ref_flush_left;
  logic [31:0] ref_br, ref_mp;

  function automatic void model_reset();
    for (int i = 0; i < BHT_ENTRIES; i++) ref_bht[i] = 1;
    ref_flush_left = 0;
    ref_br = 0;
    ref_mp = 0;
  endfunction

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % BHT_ENTRIES);
  endfunction

  function automatic bit ref_taken(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    if (op[4]) return 1'b1;
    if (!op[3]) return 1'b0;
    case (op[2:0])
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit ref_cond();
    return ex_valid && (br_op[4:3] == 2'b01) && (ref_flush_left == 0);
  endfunction

  function automatic bit ref_misp();
    return ref_cond() && (ref_taken(br_op, rs1, rs2) != ex_pred);
  endfunction

  function automatic bit ref_pred(logic [31:0] pc);
    return ref_bht[idx_of(pc)] >= 2;
  endfunction

  function automatic logic [31:0] exp_br();
`ifdef BRU_PERF_CNT_EN
    return ref_br;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_mp();
`ifdef BRU_PERF_CNT_EN
    return ref_mp;
`else
    return 32'd0;
`endif
  endfunction

  function automatic void model_edge();
    int  i;
    bit  t;
    if (ref_flush_left > 0) begin
      ref_flush_left--;
      return;
    end
    if (!ref_cond()) return;
    t = ref_taken(br_op, rs1, rs2);
    i = idx_of(ex_pc);
    if (t) ref_bht[i] = (ref_bht[i] == 3) ? 3 : ref_bht[i] + 1;
    else   ref_bht[i] = (ref_bht[i] == 0) ? 0 : ref_bht[i] - 1;
    ref_br++;
    if (t != ex_pred) begin
      ref_mp++;
      ref_flush_left = FLUSH_CYCLES;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic p,
                        input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_valid = v; ex_pc = pc; ex_pred = p; br_op = op; rs1 = a; rs2 = b;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [3];
    pcs[0] = 32'h00; pcs[1] = 32'h44; pcs[2] = 32'hFC;
    foreach (pcs[k]) begin
      fetch_pc = pcs[k];
      #1;
      checks++;
      if (pred_taken !== 1'b0) begin
        errors++; $display("FAIL reset_pred pc=%0h got %0b expected 0", pcs[k], pred_taken);
      end
    end
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b expected 0", flush); end
    checks++;
    if (br_cnt !== '0 || mp_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt got br=%0d mp=%0d expected 0 0", br_cnt, mp_cnt);
    end
  endtask

  task automatic test_beq_mispredict();
    fetch_pc = 32'h44;
    set_ex(1'b1, 32'h44, 1'b0, 5'b01000, 32'd7, 32'd7);
    checks++;
    if (next_pc_src !== 1'b1 || mispredict !== 1'b1) begin
      errors++; $display("FAIL beq_resolve got npc=%0b misp=%0b expected 1 1", next_pc_src, mispredict);
    end
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 5'b00000, 32'd0, 32'd0);
    for (int c = 0; c < FLUSH_CYCLES; c++) begin
      checks++;
      if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush_cycle%0d got %0b expected 1", c, flush); end
      tick();
    end
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL beq_flush_end got %0b expected 0", flush); end
    fetch_pc = 32'h44; #1;
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_pred_44 got %0b expected 1", pred_taken); end
    fetch_pc = 32'h84; #1;
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_pred_alias_84 got %0b expected 1", pred_taken); end
    checks++;
    if (mp_cnt !== exp_mp() || br_cnt !== exp_br()) begin
      errors++; $display("FAIL beq_cnt got br=%0d mp=%0d expected %0d %0d", br_cnt, mp_cnt, exp_br(), exp_mp());
    end
  endtask

  task automatic test_compares();
    logic [4:0] ops [4];
    logic       want [4];
    ops[0] = 5'b01100; want[0] = 1'b1;
    ops[1] = 5'b01110; want[1] = 1'b0;
    ops[2] = 5'b01101; want[2] = 1'b0;
    ops[3] = 5'b01111; want[3] = 1'b1;
    foreach (ops[k]) begin
      set_ex(1'b0, 32'h10, 1'b0, ops[k], 32'hFFFF_FFFF, 32'h1);
      checks++;
      if (next_pc_src !== want[k] || mispredict !== 1'b0) begin
        errors++; $display("FAIL cmp_op%05b got npc=%0b misp=%0b expected %0b 0", ops[k], next_pc_src, mispredict, want[k]);
      end
    end
    set_ex(1'b0, 32'h10, 1'b0, 5'b01001, 32'd15, 32'd15);
    checks++;
    if (next_pc_src !== 1'b0) begin errors++; $display("FAIL cmp_bne_equal got %0b expected 0", next_pc_src); end
    tick();
  endtask

  task automatic test_bht_saturation();
    fetch_pc = 32'h48;
    for (int n = 0; n < 4; n++) begin
      set_ex(1'b1, 32'h48, 1'b1, 5'b01111, 32'd5, 32'd3);
      checks++;
      if (mispredict !== 1'b0) begin errors++; $display("FAIL sat_taken%0d misp got %0b expected 0", n, mispredict); end
      tick();
    end
    set_ex(1'b1, 32'h48, 1'b0, 5'b01111, 32'd1, 32'd5);
    tick();
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_nt1_pred got %0b expected 1", pred_taken); end
    tick();
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_nt2_pred got %0b expected 0", pred_taken); end
    // Mispredict to enter FLUSH, then keep presenting mispredicting branches.
    set_ex(1'b1, 32'h48, 1'b0, 5'b01111, 32'd5, 32'd3);
    tick();
    for (int c = 0; c < FLUSH_CYCLES; c++) begin
      checks++;
      if (flush !== 1'b1 || mispredict !== 1'b0 || next_pc_src !== 1'b1) begin
        errors++; $display("FAIL squash_cycle%0d got flush=%0b misp=%0b npc=%0b expected 1 0 1", c, flush, mispredict, next_pc_src);
      end
      tick();
    end
    set_ex(1'b0, 32'h0, 1'b0, 5'b00000, 32'd0, 32'd0);
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL squash_no_extend got %0b expected 0", flush); end
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL squash_pred got %0b expected 1", pred_taken); end
    set_ex(1'b1, 32'h48, 1'b0, 5'b01111, 32'd1, 32'd5);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 5'b00000, 32'd0, 32'd0);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL squash_no_update got %0b expected 0", pred_taken); end
    checks++;
    if (br_cnt !== exp_br() || mp_cnt !== exp_mp()) begin
      errors++; $display("FAIL sat_cnt got br=%0d mp=%0d expected %0d %0d", br_cnt, mp_cnt, exp_br(), exp_mp());
    end
  endtask

  task automatic test_reset_mid_flush();
    fetch_pc = 32'h44;
    set_ex(1'b1, 32'h44, 1'b1, 5'b01000, 32'd7, 32'd8);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 5'b00000, 32'd0, 32'd0);
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL rstmid_in_flush got %0b expected 1", flush); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL rstmid_flush_async got %0b expected 0", flush); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || br_cnt !== '0 || mp_cnt !== '0 || flush !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got pred=%0b br=%0d mp=%0d flush=%0b expected 0 0 0 0", pred_taken, br_cnt, mp_cnt, flush);
    end
  endtask

  task automatic test_jumps_and_nops();
    fetch_pc = 32'h44;
    set_ex(1'b1, 32'h44, 1'b0, 5'b10000, 32'd1, 32'd2);
    checks++;
    if (next_pc_src !== 1'b1 || mispredict !== 1'b0) begin
      errors++; $display("FAIL jump got npc=%0b misp=%0b expected 1 0", next_pc_src, mispredict);
    end
    tick();
    tick();
    checks++;
    if (flush !== 1'b0 || pred_taken !== 1'b0) begin
      errors++; $display("FAIL jump_side got flush=%0b pred=%0b expected 0 0", flush, pred_taken);
    end
    set_ex(1'b1, 32'h44, 1'b1, 5'b00000, 32'd3, 32'd3);
    checks++;
    if (next_pc_src !== 1'b0 || mispredict !== 1'b0) begin
      errors++; $display("FAIL nobranch got npc=%0b misp=%0b expected 0 0", next_pc_src, mispredict);
    end
    tick();
    set_ex(1'b1, 32'h44, 1'b0, 5'b01010, 32'd3, 32'd3);
    checks++;
    if (next_pc_src !== 1'b0) begin errors++; $display("FAIL op01010 got %0b expected 0", next_pc_src); end
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 5'b00000, 32'd0, 32'd0);
    checks++;
    if (pred_taken !== 1'b0 || flush !== 1'b0) begin
      errors++; $display("FAIL nop_side got pred=%0b flush=%0b expected 0 0", pred_taken, flush);
    end
  endtask

  task automatic test_random();
    logic [4:0]  ops [10];
    logic [31:0] a, b;
    ops[0] = 5'b00000; ops[1] = 5'b01000; ops[2] = 5'b01001; ops[3] = 5'b01100;
    ops[4] = 5'b01101; ops[5] = 5'b01110; ops[6] = 5'b01111; ops[7] = 5'b01010;
    ops[8] = 5'b10000; ops[9] = 5'b11111;
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 8)));
      fetch_pc = $urandom & 32'hFC;
      set_ex($urandom_range(0, 4) != 0, $urandom & 32'hFC, 1'($urandom_range(0, 1)),
             ops[$urandom_range(0, 9)], a, b);
      checks++;
      if (next_pc_src !== ref_taken(br_op, rs1, rs2) || mispredict !== ref_misp() ||
          flush !== (ref_flush_left > 0) || pred_taken !== ref_pred(fetch_pc)) begin
        errors++;
        $display("FAIL rand%0d op=%05b got npc=%0b misp=%0b flush=%0b pred=%0b expected %0b %0b %0b %0b",
                 n, br_op, next_pc_src, mispredict, flush, pred_taken,
                 ref_taken(br_op, rs1, rs2), ref_misp(), ref_flush_left > 0, ref_pred(fetch_pc));
      end
      tick();
      if (n % 50 == 49) begin
        checks++;
        if (br_cnt !== exp_br() || mp_cnt !== exp_mp()) begin
          errors++; $display("FAIL rand_cnt%0d got br=%0d mp=%0d expected %0d %0d", n, br_cnt, mp_cnt, exp_br(), exp_mp());
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_pred = 1'b0;
    rs1 = '0; rs2 = '0; br_op = 5'b00000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    test_reset();
    test_beq_mispredict();
    test_compares();
    test_bht_saturation();
    test_reset_mid_flush();
    test_jumps_and_nops();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
